// File: rtl/adderc_mp.sv
// Multi-precision add/subtract sequencer: streams WIDTH-bit words LSW first,
// chaining carry/borrow across NWORDS words and emitting one registered result per word.
module adderc_mp #(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub_nadd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_cout,
    output logic             busy
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             carry_reg;
    logic             op_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic             out_cout_reg;
    logic             busy_reg;

    logic             accept;
    logic             consume;
    logic             first_word;
    logic             last_word;
    logic             sub_eff;
    logic             cin;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    assign in_ready   = enable && (!out_valid_reg || out_ready);
    assign accept     = in_valid && in_ready;
    assign consume    = enable && out_valid_reg && out_ready;
    assign first_word = (state_reg == IDLE);
    assign last_word  = (idx_reg == LAST_IDX);

    // Word 0 takes the op straight from the input; later words use the latched op
    // and the carry chained from the previous word.
    assign sub_eff = first_word ? in_sub_nadd : op_reg;
    assign cin     = first_word ? in_sub_nadd : carry_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_eff[gi] = in_b[gi] ^ sub_eff;
        end
    endgenerate

    assign sum = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (accept) begin
            if (last_word) begin
                state_next = IDLE;
                idx_next   = '0;
            end else begin
                state_next = RUN;
                idx_next   = idx_reg + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            op_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_cout_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            busy_reg  <= (state_next == RUN);
            if (accept) begin
                carry_reg    <= sum[WIDTH];
                out_data_reg <= sum[WIDTH-1:0];
                out_last_reg <= last_word;
                out_cout_reg <= last_word & sum[WIDTH];
                if (first_word) begin
                    op_reg <= in_sub_nadd;
                end
            end
            if (accept) begin
                out_valid_reg <= 1'b1;
            end else if (consume) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_cout  = out_cout_reg;
    assign busy      = busy_reg;

endmodule
